function_unit_x: RTL and testbench

Multi-cycle, parametrised successor to the single-cycle MSP430 function unit. It executes the two-operand, shift and decimal operations in byte, word or address (MSP430X) width. An operation can repeat 1..2^REP_W times, which serves the extended-instruction repeat prefix. The block sits between operand fetch and writeback in the CPU datapath and talks to the control unit through a start/busy/done handshake.

---
 rtl/function_unit_x.sv | 260 ++++++++++++++++++++++++++
 tb/tb_function_unit_x.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/function_unit_x.sv
// function_unit_x
//   Multi-cycle MSP430/MSP430X function unit. Executes two-operand, shift and
//   decimal ops in byte, word or address width, repeated rep+1 times.
//   Build option: define DADD_EN to implement DADD. Without it, DADD is
//   reported with ill=1, and result/flags pass through.
//
// Ports
//   clk, rst                 clock, async active-high reset
//   start                    request, sampled only while idle
//   op[3:0], size[1:0], rep  operation, width (00 byte, 01/11 word, 10 addr),
//                            repeat count
//   src, dst                 operands
//   Zin, Vin, Nin, Cin       status in
//   busy, done, ill          handshake; done is a one-cycle pulse
//   result                   registered result, zero above the active width
//   Zout, Vout, Nout, Cout   registered status out
module function_unit_x #(
    parameter int WIDTH = 20,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [1:0]       size,
    input  logic [REP_W-1:0] rep,
    input  logic [WIDTH-1:0] src,
    input  logic [WIDTH-1:0] dst,
    input  logic             Zin,
    input  logic             Vin,
    input  logic             Nin,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic             ill,
    output logic [WIDTH-1:0] result,
    output logic             Zout,
    output logic             Vout,
    output logic             Nout,
    output logic             Cout
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [3:0] OP_MOV  = 4'd0,  OP_ADD  = 4'd1,  OP_ADDC = 4'd2,
                           OP_SUBC = 4'd3,  OP_SUB  = 4'd4,  OP_CMP  = 4'd5,
                           OP_DADD = 4'd6,  OP_BIT  = 4'd7,  OP_BIC  = 4'd8,
                           OP_BIS  = 4'd9,  OP_XOR  = 4'd10, OP_AND  = 4'd11,
                           OP_RRC  = 4'd12, OP_RRA  = 4'd13, OP_RLA  = 4'd14,
                           OP_RRU  = 4'd15;

    function automatic logic [WIDTH-1:0] size_mask(input logic [1:0] s);
        case (s)
            2'b00:   size_mask = WIDTH'(8'hFF);
            2'b10:   size_mask = '1;
            default: size_mask = WIDTH'(16'hFFFF);
        endcase
    endfunction

    // Flag vectors are ordered {Z, V, N, C}.
    state_t             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [1:0]         size_q, size_d;
    logic [WIDTH-1:0]   src_q, src_d;
    logic [WIDTH-1:0]   dst_q, dst_d;       // working dst, fed back per iteration
    logic [3:0]         wflg_q, wflg_d;     // working flags, fed back per iteration
    logic [3:0]         oflg_q, oflg_d;     // flags presented on the outputs
    logic [REP_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               ill_q, ill_d;

    // ---------------- one iteration, from the working registers ----------------
    logic [WIDTH-1:0] mask, msbm;
    logic             d_msb, s_msb, cin;
    logic [WIDTH-1:0] add_b;
    logic             add_c;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] add_r;
    logic             add_carry, add_v;
    logic [WIDTH-1:0] it_r;
    logic             it_c, it_v, it_z, it_n;
    logic             pass_flags, keep_dst;
    logic [3:0]       it_flg;
`ifdef DADD_EN
    logic [5:0]       dd_t;
    logic             dd_c;
    logic [WIDTH-1:0] dd_r;
`endif

    always_comb begin
        mask  = size_mask(size_q);
        msbm  = mask ^ (mask >> 1);             // single bit at n-1
        d_msb = |(dst_q & msbm);
        s_msb = |(src_q & msbm);
        cin   = wflg_q[0];

        // Subtraction is dst + ~src + 1 (SUBC: + C); C is then no-borrow.
        add_b = src_q;
        add_c = 1'b0;
        case (op_q)
            OP_ADDC:        add_c = cin;
            OP_SUB, OP_CMP: begin add_b = ~src_q & mask; add_c = 1'b1; end
            OP_SUBC:        begin add_b = ~src_q & mask; add_c = cin;  end
            default: ;
        endcase
        sum       = {1'b0, dst_q} + {1'b0, add_b} + (WIDTH+1)'(add_c);
        add_r     = sum[WIDTH-1:0] & mask;
        add_carry = |(sum & ({1'b0, mask} + (WIDTH+1)'(1)));   // bit n of the sum
        add_v     = (d_msb == |(add_b & msbm)) && (|(add_r & msbm) != d_msb);

`ifdef DADD_EN
        // Nibble-serial BCD add over the active nibbles only.
        dd_c = cin;
        dd_r = '0;
        dd_t = '0;
        for (int i = 0; i < WIDTH / 4; i++) begin
            if (mask[4*i+3]) begin
                dd_t = {2'b00, dst_q[4*i +: 4]} + {2'b00, src_q[4*i +: 4]} + {5'b0, dd_c};
                if (dd_t >= 6'd10) begin
                    dd_t = dd_t + 6'd6;
                    dd_c = 1'b1;
                end else begin
                    dd_c = 1'b0;
                end
                dd_r[4*i +: 4] = dd_t[3:0];
            end
        end
`endif

        it_r       = dst_q;
        it_c       = cin;
        it_v       = wflg_q[2];
        pass_flags = 1'b0;
        keep_dst   = 1'b0;
        case (op_q)
            OP_MOV: begin it_r = src_q; pass_flags = 1'b1; end
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP: begin
                it_r = add_r; it_c = add_carry; it_v = add_v;
                keep_dst = (op_q == OP_CMP);
            end
`ifdef DADD_EN
            OP_DADD: begin it_r = dd_r; it_c = dd_c; it_v = 1'b0; end
`endif
            OP_BIT, OP_AND: begin
                it_r = dst_q & src_q; it_c = |it_r; it_v = 1'b0;
                keep_dst = (op_q == OP_BIT);
            end
            OP_BIC: begin it_r = dst_q & ~src_q; pass_flags = 1'b1; end
            OP_BIS: begin it_r = dst_q | src_q;  pass_flags = 1'b1; end
            OP_XOR: begin it_r = dst_q ^ src_q; it_c = |it_r; it_v = s_msb & d_msb; end
            OP_RRC: begin it_r = (dst_q >> 1) | (cin ? msbm : '0);   it_c = dst_q[0]; it_v = 1'b0; end
            OP_RRA: begin it_r = (dst_q >> 1) | (d_msb ? msbm : '0); it_c = dst_q[0]; it_v = 1'b0; end
            OP_RRU: begin it_r = dst_q >> 1; it_c = dst_q[0]; it_v = 1'b0; end
            OP_RLA: begin
                it_r = (dst_q << 1) & mask; it_c = d_msb;
                it_v = d_msb ^ |(it_r & msbm);
            end
            default: ;
        endcase
        it_z = ~|it_r;
        it_n = |(it_r & msbm);
        if (pass_flags) begin
            it_flg = wflg_q;
        end else begin
            it_flg = {it_z, it_v, it_n, it_c};
        end
    end

    // ---------------- sequencer ----------------
    logic dadd_skip;

    always_comb begin
`ifdef DADD_EN
        dadd_skip = 1'b0;
`else
        dadd_skip = (op_q == OP_DADD);
`endif
        state_d  = state_q;
        op_d     = op_q;
        size_d   = size_q;
        src_d    = src_q;
        dst_d    = dst_q;
        wflg_d   = wflg_q;
        oflg_d   = oflg_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ill_d    = ill_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    size_d  = size;
                    src_d   = src & size_mask(size);
                    dst_d   = dst & size_mask(size);
                    wflg_d  = {Zin, Vin, Nin, Cin};
                    cnt_d   = rep;
                    ill_d   = 1'b0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (dadd_skip) begin
                    // Unsupported op: one cycle in EXEC, then report it.
                    result_d = dst_q;
                    oflg_d   = wflg_q;
                    ill_d    = 1'b1;
                    state_d  = DONE;
                end else begin
                    result_d = it_r;
                    oflg_d   = it_flg;
                    wflg_d   = it_flg;
                    if (!keep_dst) dst_d = it_r;
                    if (cnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - REP_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            size_q   <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            wflg_q   <= '0;
            oflg_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            size_q   <= size_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            wflg_q   <= wflg_d;
            oflg_q   <= oflg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ill_q    <= ill_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign ill    = ill_q;
    assign result = result_q;
    assign Zout   = oflg_q[3];
    assign Vout   = oflg_q[2];
    assign Nout   = oflg_q[1];
    assign Cout   = oflg_q[0];

endmodule

// File: tb/tb_function_unit_x.sv
module tb_function_unit_x;

    localparam int WIDTH = 20;
    localparam int REP_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [3:0]       op = '0;
    logic [1:0]       size = '0;
    logic [REP_W-1:0] rep = '0;
    logic [WIDTH-1:0] src = '0;
    logic [WIDTH-1:0] dst = '0;
    logic             Zin = 1'b0, Vin = 1'b0, Nin = 1'b0, Cin = 1'b0;
    logic             busy, done, ill;
    logic [WIDTH-1:0] result;
    logic             Zout, Vout, Nout, Cout;

    function_unit_x #(.WIDTH(WIDTH), .REP_W(REP_W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .size(size), .rep(rep),
        .src(src), .dst(dst), .Zin(Zin), .Vin(Vin), .Nin(Nin), .Cin(Cin),
        .busy(busy), .done(done), .ill(ill), .result(result),
        .Zout(Zout), .Vout(Vout), .Nout(Nout), .Cout(Cout)
    );

    always #5 clk = ~clk;

    // Flags in {Z, V, N, C} order.
    typedef struct {
        logic [3:0]       op;
        logic [1:0]       size;
        logic [REP_W-1:0] rep;
        logic [WIDTH-1:0] src;
        logic [WIDTH-1:0] dst;
        logic [3:0]       fin;
        logic [WIDTH-1:0] eres;
        logic [3:0]       eflg;
        logic             eill;
        int               edone;
    } vec_t;

    int nerr = 0;
    int nchk = 0;

    function automatic vec_t mk(input logic [3:0] o, input logic [1:0] sz, input logic [REP_W-1:0] r,
                                input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] d, input logic [3:0] fi,
                                input logic [WIDTH-1:0] er, input logic [3:0] ef, input logic ei, input int ed);
        vec_t v;
        v.op = o; v.size = sz; v.rep = r; v.src = s; v.dst = d; v.fin = fi;
        v.eres = er; v.eflg = ef; v.eill = ei; v.edone = ed;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int flags();
        return int'({Zout, Vout, Nout, Cout});
    endfunction

    task automatic run_vec(input vec_t v, input string nm);
        int  cyc;
        bit  seen;
        bit  busy_ok;
        @(negedge clk);                       // cycle 0: present request
        op = v.op; size = v.size; rep = v.rep; src = v.src; dst = v.dst;
        {Zin, Vin, Nin, Cin} = v.fin;
        start = 1'b1;
        @(negedge clk);                       // cycle 1
        start = 1'b0;
        cyc = 1; seen = 0; busy_ok = 1;
        while (!seen && cyc <= 40) begin
            if (!busy) busy_ok = 0;
            if (done) begin
                seen = 1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk({nm, " done_cycle"}, seen ? cyc : 0, v.edone);
        chk({nm, " busy_held"}, int'(busy_ok), 1);
        if (seen) begin
            chk({nm, " result"}, int'(result), int'(v.eres));
            chk({nm, " flags"}, flags(), int'(v.eflg));
            chk({nm, " ill"}, int'(ill), int'(v.eill));
            @(negedge clk);
            chk({nm, " busy_after"}, int'(busy), 0);
            chk({nm, " done_after"}, int'(done), 0);
        end
    endtask

    vec_t v[19];

    initial begin
        int dcnt;
        v[0]  = mk(4'd1,  2'd1, 4'd0,  20'h07FFF, 20'h00001, 4'b0000, 20'h08000, 4'b0110, 1'b0, 2);
        v[1]  = mk(4'd12, 2'd2, 4'd3,  20'h00000, 20'h0000F, 4'b0000, 20'hE0000, 4'b0011, 1'b0, 5);
        v[2]  = mk(4'd4,  2'd0, 4'd0,  20'h00001, 20'h00100, 4'b0000, 20'h000FF, 4'b0010, 1'b0, 2);
`ifdef DADD_EN
        v[3]  = mk(4'd6,  2'd1, 4'd0,  20'h00199, 20'h00001, 4'b1010, 20'h00200, 4'b0000, 1'b0, 2);
`else
        v[3]  = mk(4'd6,  2'd1, 4'd0,  20'h00199, 20'h00001, 4'b1010, 20'h00001, 4'b1010, 1'b1, 2);
`endif
        v[4]  = mk(4'd14, 2'd1, 4'd1,  20'h00000, 20'h04001, 4'b0000, 20'h00004, 4'b0101, 1'b0, 3);
        v[5]  = mk(4'd5,  2'd1, 4'd1,  20'h00001, 20'h00003, 4'b0000, 20'h00002, 4'b0001, 1'b0, 3);
        v[6]  = mk(4'd2,  2'd0, 4'd1,  20'h000FF, 20'h00001, 4'b0001, 20'h00001, 4'b0001, 1'b0, 3);
        v[7]  = mk(4'd10, 2'd1, 4'd0,  20'h08001, 20'h08001, 4'b0000, 20'h00000, 4'b1100, 1'b0, 2);
        v[8]  = mk(4'd9,  2'd1, 4'd0,  20'h000F0, 20'h0000F, 4'b1101, 20'h000FF, 4'b1101, 1'b0, 2);
        v[9]  = mk(4'd13, 2'd0, 4'd0,  20'h00000, 20'h00081, 4'b0000, 20'h000C0, 4'b0011, 1'b0, 2);
        v[10] = mk(4'd15, 2'd1, 4'd0,  20'h00000, 20'h08001, 4'b0000, 20'h04000, 4'b0001, 1'b0, 2);
        v[11] = mk(4'd0,  2'd2, 4'd15, 20'hABCDE, 20'h12345, 4'b0010, 20'hABCDE, 4'b0010, 1'b0, 17);
        v[12] = mk(4'd11, 2'd1, 4'd0,  20'h00F0F, 20'h0F0F0, 4'b0000, 20'h00000, 4'b1000, 1'b0, 2);
        v[13] = mk(4'd3,  2'd1, 4'd0,  20'h00001, 20'h00001, 4'b0000, 20'h0FFFF, 4'b0010, 1'b0, 2);
        v[14] = mk(4'd1,  2'd3, 4'd0,  20'h0FFFF, 20'h00001, 4'b0000, 20'h00000, 4'b1001, 1'b0, 2);
        v[15] = mk(4'd8,  2'd2, 4'd0,  20'h0000F, 20'hFFFFF, 4'b0000, 20'hFFFF0, 4'b0000, 1'b0, 2);
        v[16] = mk(4'd1,  2'd2, 4'd1,  20'h40000, 20'h40000, 4'b0000, 20'hC0000, 4'b0010, 1'b0, 3);
        v[17] = mk(4'd7,  2'd0, 4'd2,  20'h00080, 20'h00081, 4'b0000, 20'h00080, 4'b0011, 1'b0, 4);
        v[18] = mk(4'd1,  2'd0, 4'd0,  20'h001F0, 20'h00020, 4'b0000, 20'h00010, 4'b0001, 1'b0, 2);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst ill", int'(ill), 0);
        chk("rst result", int'(result), 0);
        chk("rst flags", flags(), 0);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            run_vec(v[i], $sformatf("vec%0d", i));
        end

        // Abort: ADD rep 15, a second start mid-run, then reset in cycle 8.
        @(negedge clk);
        op = 4'd1; size = 2'd1; rep = 4'd15; src = 20'h00001; dst = 20'h00000;
        {Zin, Vin, Nin, Cin} = 4'b0000;
        start = 1'b1;                        // cycle 0
        dcnt = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (done) dcnt++;
            start = (c == 3);
            if (c == 3) begin op = 4'd0; src = 20'h0FFFF; end
            if (c == 5) begin
                chk("abort busy_c5", int'(busy), 1);
                chk("abort result_c5", int'(result), 4);
            end
        end
        chk("abort result_c8", int'(result), 7);
        rst = 1'b1;
        #1;
        chk("abort busy", int'(busy), 0);
        chk("abort result", int'(result), 0);
        chk("abort flags", flags(), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (done) dcnt++;
            @(negedge clk);
        end
        chk("abort no_done", dcnt, 0);
        run_vec(v[0], "after_abort");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
